// File: rtl/fmdsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fmdsp_pkg
// Brief    : Shared FSM state encoding and default widths for the fmdsp blocks.
// Revision : 1.0 - initial release
// ============================================================================
package fmdsp_pkg;

    localparam int c_default_width      = 8;
    localparam int c_default_shift_bits = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage : fmdsp_pkg
`default_nettype wire

// File: rtl/barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : barrel_shifter
// Brief    : Logarithmic zero-fill barrel shifter, direction 0 = left, 1 = right.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_shifter #(
    parameter int WIDTH      = 8,
    parameter int SHIFT_BITS = 3
) (
    input  logic [WIDTH-1:0]      data_in,
    input  logic [SHIFT_BITS-1:0] shift_amount,
    input  logic                  direction,
    output logic [WIDTH-1:0]      data_out
);

    logic [WIDTH-1:0] w_lvl [0:SHIFT_BITS];

    assign w_lvl[0] = data_in;

    // Level i applies a fixed 2^i shift when bit i of the amount is set
    for (genvar i = 0; i < SHIFT_BITS; i++) begin : g_level
        assign w_lvl[i+1] = !shift_amount[i] ? w_lvl[i]
                          : (direction ? (w_lvl[i] >> (2**i)) : (w_lvl[i] << (2**i)));
    end

    assign data_out = w_lvl[SHIFT_BITS];

endmodule : barrel_shifter
`default_nettype wire

// File: rtl/leading_sign_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : leading_sign_normalizer
// Brief    : Multi-cycle left normalizer for signed operands with shift count.
// Revision : 1.0 - initial release
// ============================================================================
module leading_sign_normalizer
    import fmdsp_pkg::*;
#(
    parameter int WIDTH      = c_default_width,
    parameter int SHIFT_BITS = c_default_shift_bits
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] data_out,
    output logic [SHIFT_BITS-1:0]   shift_count,
    output logic                    zero
);

    localparam logic [SHIFT_BITS-1:0] c_one        = SHIFT_BITS'(1);
    localparam logic [SHIFT_BITS-1:0] c_last_stage = SHIFT_BITS'(SHIFT_BITS - 1);

    if (SHIFT_BITS != $clog2(WIDTH)) begin : g_param_check
        $error("leading_sign_normalizer: SHIFT_BITS must equal ceil(log2(WIDTH))");
    end

    norm_state_t             r_state;
    norm_state_t             w_state_nxt;
    logic [WIDTH-1:0]        r_work;
    logic [SHIFT_BITS-1:0]   r_count;
    logic [SHIFT_BITS-1:0]   r_stage;
    logic                    r_zero;

    logic [WIDTH-1:0]        w_sign_diff;
    logic [SHIFT_BITS-1:0]   w_eq;
    logic                    w_take;
    logic [SHIFT_BITS-1:0]   w_shamt;
    logic [WIDTH-1:0]        w_shifted;

    // Bits that differ from the sign bit; a stage may shift when its mask sees none
    assign w_sign_diff = r_work ^ {WIDTH{r_work[WIDTH-1]}};

    for (genvar k = 0; k < SHIFT_BITS; k++) begin : g_stage_eq
        localparam int               c_len  = (2**k) + 1;
        localparam logic [WIDTH-1:0] c_mask = ~({WIDTH{1'b1}} >> c_len);
        assign w_eq[k] = ((w_sign_diff & c_mask) == '0);
    end

    always_comb begin
        w_take = 1'b0;
        for (int k = 0; k < SHIFT_BITS; k++) begin
            if (r_stage == SHIFT_BITS'(k)) begin
                w_take = w_eq[k];
            end
        end
        w_shamt = w_take ? (c_one << r_stage) : '0;
    end

    barrel_shifter #(
        .WIDTH      (WIDTH),
        .SHIFT_BITS (SHIFT_BITS)
    ) u_shifter (
        .data_in      (r_work),
        .shift_amount (w_shamt),
        .direction    (1'b0),
        .data_out     (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_stage == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work  <= '0;
            r_count <= '0;
            r_stage <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work  <= data_in;
                        r_count <= '0;
                        r_stage <= c_last_stage;
                        r_zero  <= (data_in == '0);
                    end
                end
                SHIFT: begin
                    r_work  <= w_shifted;
                    r_count <= r_count + w_shamt;
                    if (r_stage != '0) begin
                        r_stage <= r_stage - c_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_out    = r_work;
    assign shift_count = r_count;
    assign zero        = r_zero;

endmodule : leading_sign_normalizer
`default_nettype wire

// File: tb/tb_leading_sign_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_leading_sign_normalizer
// Brief    : Directed and back-to-back checks of the leading sign normalizer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leading_sign_normalizer;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] data_out;
    logic [2:0]        shift_count;
    logic              zero;

    int n_checks = 0;
    int n_pass   = 0;

    leading_sign_normalizer #(
        .WIDTH      (8),
        .SHIFT_BITS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .shift_count (shift_count),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: shift one bit at a time while the top two bits match
    function automatic logic [11:0] ref_model(input logic [7:0] d);
        logic [7:0] v;
        logic [2:0] c;
        v = d;
        c = 3'd0;
        while (c < 3'd7 && v[7] == v[6]) begin
            v = v << 1;
            c = c + 3'd1;
        end
        return {v, c, (d == 8'h00)};
    endfunction

    task automatic run_op(input string tag, input logic [7:0] d,
                          input logic [7:0] exp_out, input logic [2:0] exp_cnt,
                          input logic exp_zero);
        check_value({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        data_in  = d;
        tick();
        in_valid = 1'b0;
        data_in  = 8'h5A;
        tick();
        tick();
        check_value({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();
        check_value({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_value({tag, "_result"}, {20'd0, data_out, shift_count, zero},
                    {20'd0, exp_out, exp_cnt, exp_zero});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_value({tag, "_consumed"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        logic [7:0]  ops [0:99];
        logic [11:0] exp_q [$];
        logic [11:0] exp_item;
        int sent, got, cyc, last_cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_value("reset_state", {20'd0, in_ready, out_valid, data_out, shift_count, zero},
                    {20'd0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0});

        run_op("op01", 8'h01, 8'h40, 3'd6, 1'b0);
        run_op("opF0", 8'hF0, 8'h80, 3'd3, 1'b0);
        run_op("op40", 8'h40, 8'h40, 3'd0, 1'b0);
        run_op("op00", 8'h00, 8'h00, 3'd7, 1'b1);
        run_op("opFF", 8'hFF, 8'h80, 3'd7, 1'b0);
        run_op("opC0", 8'hC0, 8'h80, 3'd1, 1'b0);

        // Held result under backpressure while inputs wiggle
        in_valid = 1'b1;
        data_in  = 8'h03;
        tick();
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            data_in  = 8'(i * 37 + 1);
            in_valid = i[0];
            check_value("hold_result",
                        {20'd0, in_ready, out_valid, data_out, shift_count, zero},
                        {20'd0, 1'b0, 1'b1, 8'h60, 3'd5, 1'b0});
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_value("hold_release", 32'(in_ready), 32'd1);

        // Reset in the second shift cycle discards the operand
        in_valid = 1'b1;
        data_in  = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("mid_reset", {20'd0, in_ready, out_valid, data_out, shift_count, zero},
                    {20'd0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0});
        tick();
        check_value("mid_reset_idle", 32'(out_valid), 32'd0);
        run_op("post_rst", 8'h01, 8'h40, 3'd6, 1'b0);

        // Reset wins over in_valid in the same cycle
        rst      = 1'b1;
        in_valid = 1'b1;
        data_in  = 8'h01;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check_value("rst_priority", {30'd0, in_ready, out_valid}, 32'b10);

        // Back-to-back stream with the consumer always ready
        for (int i = 0; i < 100; i++) begin
            ops[i] = 8'($urandom_range(0, 255));
        end
        ops[0] = 8'h00;
        ops[1] = 8'hFF;
        sent      = 0;
        got       = 0;
        cyc       = 0;
        last_cyc  = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = ops[0];
        while (got < 100 && cyc < 700) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_value("b2b_spurious", 32'd1, 32'd0);
                end else begin
                    exp_item = exp_q.pop_front();
                    check_value("b2b_result", {20'd0, data_out, shift_count, zero},
                                {20'd0, exp_item});
                end
                if (last_cyc >= 0) begin
                    check_value("b2b_interval", 32'(cyc - last_cyc), 32'd5);
                end
                last_cyc = cyc;
                got++;
            end
            if (in_ready && in_valid) begin
                exp_q.push_back(ref_model(data_in));
                sent++;
            end
            tick();
            cyc++;
            if (sent < 100) begin
                data_in = ops[sent];
            end else begin
                in_valid = 1'b0;
            end
        end
        check_value("b2b_count", 32'(got), 32'd100);
        check_value("b2b_leftover", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_leading_sign_normalizer
`default_nettype wire

// File: doc/leading_sign_normalizer.md
LEADING_SIGN_NORMALIZER -- requirements
Module: leading_sign_normalizer

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits of signed two's-complement operands.
REQ-002 Parameter SHIFT_BITS, default 3, width of shift count; SHALL equal ceil(log2(WIDTH)), elaboration error otherwise.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  data_in is presented.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 data_in  input  WIDTH  signed operand to normalize.
REQ-008 out_valid  output  1  result fields are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 data_out  output  WIDTH  signed normalized value, equal to data_in shifted left by shift_count.
REQ-011 shift_count  output  SHIFT_BITS  left-shift amount applied; the exponent adjustment for a downstream right shift.
REQ-012 zero  output  1  operand was 0.

Function
REQ-013 Normalized SHALL mean value[WIDTH-1] != value[WIDTH-2]; 0 and -1 SHALL be shifted by WIDTH-1.
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 IDLE with in_valid=1: capture data_in into the working register, set count=0, stage=SHIFT_BITS-1, go to SHIFT; in_valid=0: stay in IDLE.
REQ-016 Each SHIFT cycle, stage k: if the top 2^k+1 bits of the working register are all equal, shift the register left by 2^k (zero fill) and add 2^k to count; otherwise hold both.
REQ-017 After stage 0, go to DONE; out_valid SHALL rise exactly SHIFT_BITS cycles after the accepting edge.
REQ-018 DONE: data_out, shift_count and zero SHALL stay stable while out_ready=0; out_ready=1 returns to IDLE on that edge.
REQ-019 No operand SHALL be accepted in the cycle a result is consumed; minimum initiation interval is SHIFT_BITS+2 cycles.
REQ-020 zero SHALL equal (captured operand == 0), registered at accept.
REQ-021 in_valid, data_in and out_ready changes outside IDLE or DONE respectively SHALL have no effect.
REQ-022 Count arithmetic SHALL not overflow: maximum sum is 2^SHIFT_BITS-1 >= WIDTH-1.

Reset
REQ-023 rst=1 SHALL force IDLE on the next edge from any state, including mid-SHIFT and DONE; the in-flight operand is discarded.
REQ-024 Reset values: out_valid=0, in_ready=1 (after reset edge), data_out=0, shift_count=0, zero=0, working register=0.
REQ-025 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-026 Shared package fmdsp_pkg SHALL hold the FSM state encoding (IDLE, SHIFT, DONE) and the default WIDTH/SHIFT_BITS constants.
REQ-027 One instance of the existing barrel_shifter SHALL perform the per-stage shift: direction tied 0, shift_amount = 2^k or 0 per stage test.
REQ-028 The all-equal test for the top bits SHALL be a per-stage mask compare, with no priority encoder over the full width.

Verification (WIDTH=8, SHIFT_BITS=3)
REQ-029 data_in=0x01 accepted -> 3 cycles later out_valid=1, data_out=0x40, shift_count=6, zero=0.
REQ-030 data_in=0xF0 -> data_out=0x80, shift_count=3; data_in=0x40 -> data_out=0x40, shift_count=0.
REQ-031 data_in=0x00 -> data_out=0x00, shift_count=7, zero=1; data_in=0xFF -> data_out=0x80, shift_count=7, zero=0.
REQ-032 data_in=0x03 with out_ready=0 for 5 cycles -> out_valid and data_out=0x60, shift_count=5 held stable; in_ready=0 throughout; toggling data_in has no effect.
REQ-033 rst=1 during the second SHIFT cycle -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; a following operand 0x01 yields the REQ-029 result.
REQ-034 Back-to-back in_valid=1 with out_ready=1 -> one result every 5 cycles, order preserved, no drop or duplicate over 100 random operands checked against a reference model.
